// File: rtl/rv_iopmp_bram_arbiter_pkg.sv
// Shared types and constants for the IOPMP entry-table BRAM arbiter.
// The owner index field is sized for up to 16 checker ports. Each arbiter
// instance only uses the low bits that its own checker count needs.
package rv_iopmp_bram_arbiter_pkg;

    // Width of one entry-table word.
    localparam int ENTRY_WIDTH = 128;

    // Width of the owner index field carried through the read-tag pipe.
    localparam int OWNER_IDX_W = 4;

    // Identifies who issued a BRAM read.
    typedef struct packed {
        logic                   is_cfg;
        logic [OWNER_IDX_W-1:0] idx;
    } arb_owner_t;

    // One stage of the in-flight read tracker.
    typedef struct packed {
        logic       valid;
        arb_owner_t owner;
    } rd_tag_t;

    // Index width for an n-way selection.
    // Never returns zero, so that n == 1 still gets a legal vector.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rv_iopmp_bram_arbiter_if.sv
// Bus bundle between the requesters (config path and checkers), the arbiter
// and the entry-table BRAM.
// The slave modport is the arbiter's view. The master modport is the view of
// the surrounding environment: the requesters plus the BRAM macro.
interface rv_iopmp_bram_arbiter_if #(
    parameter int N  = 1,
    parameter int AW = 3
);
    import rv_iopmp_bram_arbiter_pkg::*;

    // Config port
    logic                   cfg_req_i;
    logic                   cfg_we_i;
    logic [AW-1:0]          cfg_addr_i;
    logic [ENTRY_WIDTH-1:0] cfg_wdata_i;
    logic                   cfg_gnt_o;
    logic                   cfg_rvalid_o;

    // Checker lookup ports
    logic [N-1:0]           chk_req_i;
    logic [N*AW-1:0]        chk_addr_i;
    logic [N-1:0]           chk_gnt_o;
    logic [N-1:0]           chk_rvalid_o;

    // Shared read data
    logic [ENTRY_WIDTH-1:0] rdata_o;

    // BRAM port
    logic                   bram_en_o;
    logic                   bram_we_o;
    logic [AW-1:0]          bram_addr_o;
    logic [ENTRY_WIDTH-1:0] bram_din_o;
    logic [ENTRY_WIDTH-1:0] bram_dout_i;

    modport slave (
        input  cfg_req_i, cfg_we_i, cfg_addr_i, cfg_wdata_i,
        input  chk_req_i, chk_addr_i,
        input  bram_dout_i,
        output cfg_gnt_o, cfg_rvalid_o,
        output chk_gnt_o, chk_rvalid_o,
        output rdata_o,
        output bram_en_o, bram_we_o, bram_addr_o, bram_din_o
    );

    modport master (
        output cfg_req_i, cfg_we_i, cfg_addr_i, cfg_wdata_i,
        output chk_req_i, chk_addr_i,
        output bram_dout_i,
        input  cfg_gnt_o, cfg_rvalid_o,
        input  chk_gnt_o, chk_rvalid_o,
        input  rdata_o,
        input  bram_en_o, bram_we_o, bram_addr_o, bram_din_o
    );

endinterface

// File: rtl/rv_iopmp_bram_arbiter_rr.sv
// N-way round-robin pick.
// The search starts at ptr_i and wraps modulo N. The first requester found
// wins. The result is a one-hot grant plus the binary index of the winner.
// The block is purely combinational: the caller owns the pointer register.
module rv_iopmp_rr_arbiter #(
    parameter int N  = 1,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    int cand;

    // Scan N candidates starting at the pointer and keep the first requester.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = 0;
        for (int i = 0; i < N; i++) begin
            cand = int'(ptr_i) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/rv_iopmp_bram_arbiter.sv
// rv_iopmp_bram_arbiter: shares the single-port 128-bit IOPMP entry-table BRAM
// between the config path and N checker lookup ports.
//
// Arbitration:
// - The config port has fixed priority.
// - A streak counter bounds how long checkers can be starved by back-to-back
//   config grants.
// - Checkers are served round-robin among themselves.
//
// Read routing:
// - A tag pipe as deep as the BRAM read latency remembers who issued each
//   read. The returning data is therefore flagged only for that requester.
//
// Optional feature (macro RV_IOPMP_BRAM_ARB_STATS_EN):
// - When defined, adds stall_cnt_o. It is a saturating count of cycles in
//   which at least one request was pending and not granted.
module rv_iopmp_bram_arbiter
    import rv_iopmp_bram_arbiter_pkg::*;
#(
    parameter int NUMBER_ENTRIES         = 8,
    parameter int NUMBER_IOPMP_INSTANCES = 1,
    parameter int BRAM_LATENCY           = 1,
    parameter int CFG_MAX_STREAK         = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        iopmp_enabled_i,
`ifdef RV_IOPMP_BRAM_ARB_STATS_EN
    output logic [15:0] stall_cnt_o,
`endif
    rv_iopmp_bram_arbiter_if.slave bus
);

    localparam int N  = NUMBER_IOPMP_INSTANCES;
    localparam int AW = $clog2(NUMBER_ENTRIES);
    localparam int IW = idx_width(N);
    localparam int SW = $clog2(CFG_MAX_STREAK + 1);

    genvar gi;

    // Arbitration state
    logic [IW-1:0] rr_ptr_reg;
    logic [IW-1:0] rr_ptr_next;
    logic [SW-1:0] streak_reg;
    logic [SW-1:0] streak_next;

    // Read tag pipe; stage 0 is the newest entry
    rd_tag_t tag_pipe_reg [BRAM_LATENCY];
    rd_tag_t tag_push;
    rd_tag_t tag_tail;

    // Arbitration results
    logic [N-1:0]  chk_elig;
    logic [N-1:0]  rr_gnt;
    logic [IW-1:0] rr_idx;
    logic          rr_any;
    logic          chk_pending;
    logic          cfg_blocked;
    logic          cfg_win;
    logic          chk_win;
    logic [AW-1:0] chk_addr_sel;
    logic [N-1:0]  chk_rvalid;

    // Checkers are only eligible while the IOPMP is enabled.
    assign chk_elig = bus.chk_req_i & {N{iopmp_enabled_i}};

    rv_iopmp_rr_arbiter #(
        .N  (N),
        .IW (IW)
    ) u_rr (
        .req_i (chk_elig),
        .ptr_i (rr_ptr_reg),
        .gnt_o (rr_gnt),
        .idx_o (rr_idx),
        .any_o (rr_any)
    );

    // Pick the single winner of this cycle.
    // Config is blocked only when the streak is exhausted while a checker waits.
    // Nothing is granted while reset is asserted.
    always_comb begin
        chk_pending = rst_ni & rr_any;
        cfg_blocked = chk_pending && (streak_reg == SW'(CFG_MAX_STREAK));
        cfg_win     = rst_ni && bus.cfg_req_i && !cfg_blocked;
        chk_win     = chk_pending && !cfg_win;
    end

    assign chk_addr_sel = bus.chk_addr_i[rr_idx*AW +: AW];

    // Drive the BRAM port and the grants from the winner in the same cycle.
    always_comb begin
        bus.cfg_gnt_o   = cfg_win;
        bus.chk_gnt_o   = chk_win ? rr_gnt : '0;
        bus.bram_en_o   = cfg_win | chk_win;
        bus.bram_we_o   = cfg_win & bus.cfg_we_i;
        bus.bram_addr_o = '0;
        bus.bram_din_o  = '0;
        if (cfg_win) begin
            bus.bram_addr_o = bus.cfg_addr_i;
            if (bus.cfg_we_i) begin
                bus.bram_din_o = bus.cfg_wdata_i;
            end
        end else if (chk_win) begin
            bus.bram_addr_o = chk_addr_sel;
        end
    end

    // Next streak and round-robin pointer.
    // The streak only counts config grants taken while a checker is waiting.
    always_comb begin
        streak_next = streak_reg;
        rr_ptr_next = rr_ptr_reg;
        if (!chk_pending || chk_win) begin
            streak_next = '0;
        end else if (cfg_win && (streak_reg != SW'(CFG_MAX_STREAK))) begin
            streak_next = streak_reg + SW'(1);
        end
        if (chk_win) begin
            rr_ptr_next = (rr_idx == IW'(N - 1)) ? '0 : rr_idx + IW'(1);
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_ptr_reg <= '0;
            streak_reg <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
            streak_reg <= streak_next;
        end
    end

    // Tag for this cycle. Only a granted read produces a valid tag.
    always_comb begin
        tag_push              = '0;
        tag_push.valid        = (cfg_win & ~bus.cfg_we_i) | chk_win;
        tag_push.owner.is_cfg = cfg_win;
        tag_push.owner.idx    = cfg_win ? '0 : OWNER_IDX_W'(rr_idx);
    end

    // Shift the tag pipe every cycle so it stays aligned with the BRAM latency.
    // Reset drops every in-flight read.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < BRAM_LATENCY; i++) begin
                tag_pipe_reg[i] <= '0;
            end
        end else begin
            tag_pipe_reg[0] <= tag_push;
            for (int i = 1; i < BRAM_LATENCY; i++) begin
                tag_pipe_reg[i] <= tag_pipe_reg[i-1];
            end
        end
    end

    assign tag_tail = tag_pipe_reg[BRAM_LATENCY-1];

    // Per-checker return strobe and the request-hold rule.
    generate
        for (gi = 0; gi < N; gi++) begin : g_chk
            assign chk_rvalid[gi] = rst_ni & tag_tail.valid & ~tag_tail.owner.is_cfg &
                                    (tag_tail.owner.idx == OWNER_IDX_W'(gi));

            chk_hold_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
                (bus.chk_req_i[gi] && !bus.chk_gnt_o[gi]) |=> bus.chk_req_i[gi]);
        end
    endgenerate

    // Route the data returning from the BRAM to the owner recorded in the tail tag.
    always_comb begin
        bus.chk_rvalid_o = chk_rvalid;
        bus.cfg_rvalid_o = rst_ni & tag_tail.valid & tag_tail.owner.is_cfg;
        bus.rdata_o      = (rst_ni && tag_tail.valid) ? bus.bram_dout_i : '0;
    end

    // A config request may not be withdrawn before it is granted.
    cfg_hold_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (bus.cfg_req_i && !bus.cfg_gnt_o) |=> bus.cfg_req_i);

`ifdef RV_IOPMP_BRAM_ARB_STATS_EN
    logic        stall_cycle;
    logic [15:0] stall_cnt_reg;

    assign stall_cycle = (bus.cfg_req_i & ~cfg_win) |
                         (|(bus.chk_req_i & ~bus.chk_gnt_o));

    // Saturating count of cycles that left at least one requester waiting.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stall_cnt_reg <= '0;
        end else if (stall_cycle && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_reg;
`endif

endmodule
